// File: rtl/rf_hilo_pkg.sv
// Shared register-file definitions: GPR address/data types and the writeback
// HI/LO bus field layout used by both the register file and writeback.
package rf_hilo_pkg;

    localparam int REG_W    = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] RegAddrBus;
    typedef logic [REG_W-1:0]  RegBus;

    localparam RegBus     ZeroWord   = '0;
    localparam RegAddrBus NOPRegAddr = '0;

    localparam int HILO_W      = 2 + 2 * REG_W;
    localparam int HILO_HI_WE  = 65;
    localparam int HILO_LO_WE  = 64;
    localparam int HILO_HI_MSB = 63;
    localparam int HILO_HI_LSB = 32;
    localparam int HILO_LO_MSB = 31;
    localparam int HILO_LO_LSB = 0;

    typedef logic [HILO_W-1:0] HiloBus;

    function automatic HiloBus pack_hilo(logic hi_we, logic lo_we, RegBus hi, RegBus lo);
        HiloBus v;
        v = '0;
        v[HILO_HI_WE]                  = hi_we;
        v[HILO_LO_WE]                  = lo_we;
        v[HILO_HI_MSB:HILO_HI_LSB]     = hi;
        v[HILO_LO_MSB:HILO_LO_LSB]     = lo;
        return v;
    endfunction

endpackage

// File: rtl/rf_hilo_if.sv
// Register-file bus: two combinational read ports, one GPR write port from
// writeback, the HI/LO writeback bus and the HI/LO read values.
interface rf_hilo_if;
    import rf_hilo_pkg::*;

    RegAddrBus raddr1;
    RegBus     rdata1;
    RegAddrBus raddr2;
    RegBus     rdata2;
    logic      we;
    RegAddrBus waddr;
    RegBus     wdata;
    HiloBus    hilo_bus;
    RegBus     hi_o;
    RegBus     lo_o;

    modport master (
        output raddr1, raddr2, we, waddr, wdata, hilo_bus,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata, hilo_bus,
        output rdata1, rdata2, hi_o, lo_o
    );

endinterface

// File: rtl/rf_hilo.sv
// 32x32 GPR file with HI/LO registers; optional same-cycle write forwarding to
// every read output. All outputs are forced to zero while rst is low.
module rf_hilo
    import rf_hilo_pkg::*;
#(
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    rf_hilo_if.slave   bus
);

    RegBus r_gpr [NUM_REGS];
    RegBus r_hi;
    RegBus r_lo;

    logic  w_gpr_we;
    logic  w_hi_we;
    logic  w_lo_we;
    RegBus w_hi_wdata;
    RegBus w_lo_wdata;
    RegBus w_rdata1;
    RegBus w_rdata2;
    RegBus w_hi;
    RegBus w_lo;

    assign w_gpr_we   = bus.we && (bus.waddr != NOPRegAddr);
    assign w_hi_we    = bus.hilo_bus[HILO_HI_WE];
    assign w_lo_we    = bus.hilo_bus[HILO_LO_WE];
    assign w_hi_wdata = bus.hilo_bus[HILO_HI_MSB:HILO_HI_LSB];
    assign w_lo_wdata = bus.hilo_bus[HILO_LO_MSB:HILO_LO_LSB];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_gpr[i] <= ZeroWord;
            end
            r_hi <= ZeroWord;
            r_lo <= ZeroWord;
        end else begin
            if (w_gpr_we) begin
                r_gpr[bus.waddr] <= bus.wdata;
            end
            if (w_hi_we) begin
                r_hi <= w_hi_wdata;
            end
            if (w_lo_we) begin
                r_lo <= w_lo_wdata;
            end
        end
    end

    // Index 0 is hardwired to zero on read, independent of stored contents.
    always_comb begin
        w_rdata1 = ZeroWord;
        if (!rst || bus.raddr1 == NOPRegAddr) begin
            w_rdata1 = ZeroWord;
        end else if (RF_BYPASS && w_gpr_we && bus.waddr == bus.raddr1) begin
            w_rdata1 = bus.wdata;
        end else begin
            w_rdata1 = r_gpr[bus.raddr1];
        end
    end

    always_comb begin
        w_rdata2 = ZeroWord;
        if (!rst || bus.raddr2 == NOPRegAddr) begin
            w_rdata2 = ZeroWord;
        end else if (RF_BYPASS && w_gpr_we && bus.waddr == bus.raddr2) begin
            w_rdata2 = bus.wdata;
        end else begin
            w_rdata2 = r_gpr[bus.raddr2];
        end
    end

    always_comb begin
        w_hi = ZeroWord;
        w_lo = ZeroWord;
        if (rst) begin
            w_hi = (RF_BYPASS && w_hi_we) ? w_hi_wdata : r_hi;
            w_lo = (RF_BYPASS && w_lo_we) ? w_lo_wdata : r_lo;
        end
    end

    assign bus.rdata1 = w_rdata1;
    assign bus.rdata2 = w_rdata2;
    assign bus.hi_o   = w_hi;
    assign bus.lo_o   = w_lo;

endmodule

// File: tb/tb_rf_hilo.sv
// Directed and randomized checks of rf_hilo with forwarding enabled and
// disabled, both instances driven with identical stimulus.
module tb_rf_hilo;
    import rf_hilo_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_hilo_if if_b ();
    rf_hilo_if if_n ();

    rf_hilo #(.RF_BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    rf_hilo #(.RF_BYPASS(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(if_n));

    int    total = 0;
    int    bad   = 0;
    RegBus m_gpr [NUM_REGS];
    RegBus m_hi;
    RegBus m_lo;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic we_v, RegAddrBus wa, RegBus wd, HiloBus hl,
                         RegAddrBus r1, RegAddrBus r2);
        if_b.we = we_v;  if_b.waddr = wa;  if_b.wdata = wd;
        if_b.hilo_bus = hl;  if_b.raddr1 = r1;  if_b.raddr2 = r2;
        if_n.we = we_v;  if_n.waddr = wa;  if_n.wdata = wd;
        if_n.hilo_bus = hl;  if_n.raddr1 = r1;  if_n.raddr2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all(string tag, RegBus e1, RegBus e2, RegBus eh, RegBus el);
        chk({tag, "_b_rd1"}, if_b.rdata1, e1);
        chk({tag, "_b_rd2"}, if_b.rdata2, e2);
        chk({tag, "_b_hi"},  if_b.hi_o,   eh);
        chk({tag, "_b_lo"},  if_b.lo_o,   el);
        chk({tag, "_n_rd1"}, if_n.rdata1, e1);
        chk({tag, "_n_rd2"}, if_n.rdata2, e2);
        chk({tag, "_n_hi"},  if_n.hi_o,   eh);
        chk({tag, "_n_lo"},  if_n.lo_o,   el);
    endtask

    function automatic RegBus exp_rd(bit byp, RegAddrBus ra, logic we_v, RegAddrBus wa, RegBus wd);
        if (ra == 5'd0) return 32'h0;
        if (byp && we_v && wa != 5'd0 && wa == ra) return wd;
        return m_gpr[ra];
    endfunction

    initial begin
        // reset with writes and bypass requests active
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h33, pack_hilo(1'b1, 1'b1, 32'h77, 32'h88), 5'd3, 5'd3);
        settle();
        chk_all("rst_hold", 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk_all("rst_edge", 32'h0, 32'h0, 32'h0, 32'h0);
        rst = 1'b1;

        // first edge after release accepts a write
        drive(1'b1, 5'd5, 32'h12345678, '0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, '0, 5'd5, 5'd3);
        settle();
        chk("wr5_b", if_b.rdata1, 32'h12345678);
        chk("wr5_n", if_n.rdata1, 32'h12345678);
        chk("rd3_after_rst_n", if_n.rdata2, 32'h0);

        // writes to index 0 are dropped and never forwarded
        drive(1'b1, 5'd0, 32'hFFFFFFFF, '0, 5'd0, 5'd0);
        settle();
        chk("z_same_b1", if_b.rdata1, 32'h0);
        chk("z_same_b2", if_b.rdata2, 32'h0);
        chk("z_same_n1", if_n.rdata1, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, '0, 5'd0, 5'd0);
        settle();
        chk("z_after_b1", if_b.rdata1, 32'h0);
        chk("z_after_n2", if_n.rdata2, 32'h0);

        // same-cycle forwarding vs stored value
        drive(1'b1, 5'd7, 32'hA, '0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'hB, '0, 5'd7, 5'd7);
        settle();
        chk("byp_b1", if_b.rdata1, 32'hB);
        chk("byp_b2", if_b.rdata2, 32'hB);
        chk("nobyp_n1", if_n.rdata1, 32'hA);
        chk("nobyp_n2", if_n.rdata2, 32'hA);
        tick();
        drive(1'b0, 5'd7, 32'h0, '0, 5'd7, 5'd7);
        settle();
        chk("post7_b1", if_b.rdata1, 32'hB);
        chk("post7_n2", if_n.rdata2, 32'hB);

        // independent HI and LO enables
        drive(1'b0, 5'd0, 32'h0, pack_hilo(1'b1, 1'b0, 32'hDEAD0000, 32'h1111), 5'd0, 5'd0);
        settle();
        chk("hi_byp_b", if_b.hi_o, 32'hDEAD0000);
        chk("lo_keep_b", if_b.lo_o, 32'h0);
        chk("hi_nobyp_n", if_n.hi_o, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, pack_hilo(1'b0, 1'b1, 32'hBAD0BAD0, 32'h2222), 5'd0, 5'd0);
        settle();
        chk("lo_byp_b", if_b.lo_o, 32'h2222);
        chk("hi_hold_b", if_b.hi_o, 32'hDEAD0000);
        chk("lo_nobyp_n", if_n.lo_o, 32'h0);
        chk("hi_hold_n", if_n.hi_o, 32'hDEAD0000);
        tick();
        drive(1'b0, 5'd0, 32'h0, '0, 5'd0, 5'd0);
        settle();
        chk_all("hilo_post", 32'h0, 32'h0, 32'hDEAD0000, 32'h2222);

        // all enables low with garbage on the data inputs
        drive(1'b0, 5'd13, 32'hCAFEF00D, pack_hilo(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF), 5'd13, 5'd7);
        settle();
        chk_all("idle_same", 32'h0, 32'hB, 32'hDEAD0000, 32'h2222);
        tick();
        chk_all("idle_post", 32'h0, 32'hB, 32'hDEAD0000, 32'h2222);

        // GPR and HI/LO written at the same edge
        drive(1'b1, 5'd9, 32'h99, pack_hilo(1'b1, 1'b1, 32'h55, 32'h55), 5'd9, 5'd5);
        settle();
        chk("both_same_b", if_b.rdata1, 32'h99);
        chk("both_same_n", if_n.rdata1, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, '0, 5'd9, 5'd5);
        settle();
        chk_all("both_post", 32'h99, 32'h12345678, 32'h55, 32'h55);

        // fill GPRs with their index, then reset between edges
        for (int i = 1; i < NUM_REGS; i++) begin
            drive(1'b1, RegAddrBus'(i), RegBus'(i), '0, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, '0, 5'd31, 5'd1);
        settle();
        chk_all("fill", 32'd31, 32'd1, 32'h55, 32'h55);
        drive(1'b1, 5'd4, 32'hFFFF, pack_hilo(1'b1, 1'b1, 32'hAAAA, 32'hBBBB), 5'd4, 5'd4);
        settle();
        chk("inflight_b", if_b.rdata1, 32'hFFFF);
        #2;
        rst = 1'b0;
        #1;
        chk_all("rst_mid", 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, '0, 5'd4, 5'd4);
        settle();
        chk_all("rst_rel", 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < NUM_REGS; i++) begin
            drive(1'b0, 5'd0, 32'h0, '0, RegAddrBus'(i), RegAddrBus'(31 - i));
            settle();
            chk("clr_n1", if_n.rdata1, 32'h0);
            chk("clr_b2", if_b.rdata2, 32'h0);
        end
        tick();
        drive(1'b1, 5'd4, 32'h44, '0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, '0, 5'd4, 5'd5);
        settle();
        chk("rewrite_n", if_n.rdata1, 32'h44);
        chk("unwritten_n", if_n.rdata2, 32'h0);

        // randomized sequence against a reference model
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        for (int c = 0; c < 10000; c++) begin
            logic      r_we;
            RegAddrBus r_wa;
            RegAddrBus r_r1;
            RegAddrBus r_r2;
            RegBus     r_wd;
            RegBus     r_hd;
            RegBus     r_ld;
            logic      r_hwe;
            logic      r_lwe;
            r_we  = 1'($urandom_range(0, 1));
            r_wa  = 5'($urandom_range(0, 31));
            r_wd  = $urandom();
            r_hd  = $urandom();
            r_ld  = $urandom();
            r_hwe = 1'($urandom_range(0, 1));
            r_lwe = 1'($urandom_range(0, 1));
            r_r1  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_r2  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            drive(r_we, r_wa, r_wd, pack_hilo(r_hwe, r_lwe, r_hd, r_ld), r_r1, r_r2);
            settle();
            chk("rnd_b_rd1", if_b.rdata1, exp_rd(1'b1, r_r1, r_we, r_wa, r_wd));
            chk("rnd_b_rd2", if_b.rdata2, exp_rd(1'b1, r_r2, r_we, r_wa, r_wd));
            chk("rnd_b_hi", if_b.hi_o, r_hwe ? r_hd : m_hi);
            chk("rnd_b_lo", if_b.lo_o, r_lwe ? r_ld : m_lo);
            chk("rnd_n_rd1", if_n.rdata1, exp_rd(1'b0, r_r1, r_we, r_wa, r_wd));
            chk("rnd_n_rd2", if_n.rdata2, exp_rd(1'b0, r_r2, r_we, r_wa, r_wd));
            chk("rnd_n_hi", if_n.hi_o, m_hi);
            chk("rnd_n_lo", if_n.lo_o, m_lo);
            tick();
            if (r_we && r_wa != 5'd0) m_gpr[r_wa] = r_wd;
            if (r_hwe) m_hi = r_hd;
            if (r_lwe) m_lo = r_ld;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
